// File: rtl/uart_bcd_line_sender.sv
// Streams one line "DDDDDD<sep>DDDDDD\r\n" built from two latched BCD fields to a
// byte UART, handing over each byte only after the transmitter's busy flag has cycled.
module uart_bcd_line_sender #(
   parameter bit          LEADING_ZERO_BLANKING = 1'b0,
   parameter logic [7:0]  SEPARATOR             = 8'h20,
   parameter int unsigned BUSY_RISE_TIMEOUT     = 4
) (
   input  logic        clock,
   input  logic        reset_active_low,
   input  logic        start,
   input  logic [23:0] field1_bcd,
   input  logic [23:0] field2_bcd,
   input  logic        uart_busy,
   output logic        uart_wr,
   output logic [7:0]  uart_data,
   output logic        ready,
   output logic        line_done,
   output logic [7:0]  dropped_starts
);

   typedef enum logic [2:0] {IDLE, STROBE, WAIT_HI, WAIT_LO, DONE} state_t;

   localparam int unsigned   TW       = (BUSY_RISE_TIMEOUT > 1) ? $clog2(BUSY_RISE_TIMEOUT) : 1;
   localparam logic [TW-1:0] HI_LAST  = TW'(BUSY_RISE_TIMEOUT - 1);
   localparam logic [3:0]    LAST_IDX = 4'd14;

   state_t        r_state;
   state_t        w_state_nx;
   logic [3:0]    r_index;
   logic [23:0]   r_field1;
   logic [23:0]   r_field2;
   logic [7:0]    r_data_hold;
   logic          r_ready;
   logic [7:0]    r_dropped;
   logic [TW-1:0] r_hi_cnt;
   logic          w_accept;
   logic          w_wr;
   logic [7:0]    w_byte;

   // A zero digit is blanked only while every more-significant digit is also zero;
   // an invalid nybble is nonzero, so it ends the run, and the last digit always prints.
   function automatic logic [7:0] encode_digit(input logic [23:0] field, input int unsigned pos);
      logic [3:0] nyb;
      logic       leading;
      leading = 1'b1;
      for (int unsigned k = 0; k < 5; k++) begin
         if (k < pos && field[23-4*k -: 4] != 4'h0) leading = 1'b0;
      end
      nyb = field[23-4*pos -: 4];
      if (nyb > 4'd9) return 8'h3F;
      if (LEADING_ZERO_BLANKING && leading && nyb == 4'h0 && pos != 5) return 8'h20;
      return {4'h3, nyb};
   endfunction

   always_comb begin
      w_byte = 8'h0A;
      case (r_index) inside
         [4'd0:4'd5]:  w_byte = encode_digit(r_field1, 32'(r_index));
         4'd6:         w_byte = SEPARATOR;
         [4'd7:4'd12]: w_byte = encode_digit(r_field2, 32'(r_index - 4'd7));
         4'd13:        w_byte = 8'h0D;
         default:      w_byte = 8'h0A;
      endcase
   end

   assign w_accept = start && r_ready;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      w_state_nx = r_state;
      w_wr       = 1'b0;
      case (r_state)
         IDLE:    if (w_accept) w_state_nx = STROBE;
         STROBE:  if (!uart_busy) begin
                     w_wr       = 1'b1;
                     w_state_nx = WAIT_HI;
                  end
         WAIT_HI: if (uart_busy || r_hi_cnt == HI_LAST) w_state_nx = WAIT_LO;
         WAIT_LO: if (!uart_busy) w_state_nx = (r_index == LAST_IDX) ? DONE : STROBE;
         DONE:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the pre-edge values of the others.
   always_ff @(posedge clock or negedge reset_active_low) begin
      if (!reset_active_low) begin
         r_state     <= IDLE;
         r_index     <= 4'd0;
         r_field1    <= 24'h0;
         r_field2    <= 24'h0;
         r_data_hold <= 8'h20;
         r_ready     <= 1'b1;
         r_dropped   <= 8'h00;
         r_hi_cnt    <= '0;
      end else begin
         r_state <= w_state_nx;

         if (w_accept) begin
            r_field1 <= field1_bcd;
            r_field2 <= field2_bcd;
            r_index  <= 4'd0;
            r_ready  <= 1'b0;
         end else if (r_state == DONE) begin
            r_ready <= 1'b1;
         end

         if (start && !r_ready && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;

         if (r_state == WAIT_LO && !uart_busy && r_index != LAST_IDX) r_index <= r_index + 4'd1;

         r_hi_cnt <= (r_state == WAIT_HI) ? r_hi_cnt + 1'b1 : '0;

         if (w_wr) r_data_hold <= w_byte;
      end
   end

   // The byte is presented combinationally in its strobe cycle and then held until the next one.
   assign uart_wr        = w_wr;
   assign uart_data      = w_wr ? w_byte : r_data_hold;
   assign ready          = r_ready;
   assign line_done      = (r_state == DONE);
   assign dropped_starts = r_dropped;

endmodule

// File: tb/tb_uart_bcd_line_sender.sv
// Self-checking bench: two instances (blanking off/on) driven in lockstep by a
// behavioural UART busy model, lines compared against a string-building reference.
module tb_uart_bcd_line_sender;

   localparam int M_MANUAL = 0;
   localparam int M_NORMAL = 1;
   localparam int M_NEVER  = 2;

   logic        clock = 1'b0;
   logic        reset_active_low = 1'b0;
   logic        start = 1'b0;
   logic        uart_busy = 1'b0;
   logic [23:0] field1_bcd = 24'h0;
   logic [23:0] field2_bcd = 24'h0;

   logic       wr0, wr1, rdy0, rdy1, ld0_o, ld1_o;
   logic [7:0] d0, d1, dr0, dr1;

   int         tot = 0;
   int         bad = 0;
   int         cyc = 0;
   int         ld_count = 0;
   int         exp_drop = 0;
   int         mode = M_MANUAL;
   int         busy_cnt = 0;
   bit         saw_wr = 1'b0;
   bit         prev_wr = 1'b0;
   logic [7:0] last_d0 = 8'h20;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         qt[$];

   always #5 clock = ~clock;

   uart_bcd_line_sender #(.LEADING_ZERO_BLANKING(1'b0), .SEPARATOR(8'h20), .BUSY_RISE_TIMEOUT(4)) u_dut0 (
      .clock(clock), .reset_active_low(reset_active_low), .start(start),
      .field1_bcd(field1_bcd), .field2_bcd(field2_bcd), .uart_busy(uart_busy),
      .uart_wr(wr0), .uart_data(d0), .ready(rdy0), .line_done(ld0_o), .dropped_starts(dr0));

   uart_bcd_line_sender #(.LEADING_ZERO_BLANKING(1'b1), .SEPARATOR(8'h20), .BUSY_RISE_TIMEOUT(4)) u_dut1 (
      .clock(clock), .reset_active_low(reset_active_low), .start(start),
      .field1_bcd(field1_bcd), .field2_bcd(field2_bcd), .uart_busy(uart_busy),
      .uart_wr(wr1), .uart_data(d1), .ready(rdy1), .line_done(ld1_o), .dropped_starts(dr1));

   always @(posedge clock) cyc <= cyc + 1;

   // UART model: busy rises the cycle after a strobe and stays high for 10 cycles.
   always @(negedge clock) saw_wr = wr0;
   always @(posedge clock) begin
      #1;
      if (mode == M_NORMAL) begin
         if (saw_wr) begin
            uart_busy = 1'b1;
            busy_cnt  = 10;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) uart_busy = 1'b0;
         end
      end
   end

   // Byte collector plus per-cycle protocol checks.
   always @(negedge clock) begin
      if (reset_active_low) begin
         if (wr0) begin
            q0.push_back(d0);
            qt.push_back(cyc);
         end
         if (wr1) q1.push_back(d1);
         if (ld0_o) ld_count++;
         tot++;
         if (wr0 !== wr1 || ld0_o !== ld1_o) begin
            bad++;
            $display("FAIL lockstep cyc=%0d wr=%b/%b line_done=%b/%b", cyc, wr0, wr1, ld0_o, ld1_o);
         end
         tot++;
         if (wr0 === 1'b1 && prev_wr) begin
            bad++;
            $display("FAIL wr_back_to_back cyc=%0d got two strobes, want at most one", cyc);
         end
         tot++;
         if (wr0 !== 1'b1 && d0 !== last_d0) begin
            bad++;
            $display("FAIL data_hold cyc=%0d got %h want %h", cyc, d0, last_d0);
         end
         if (wr0 === 1'b1) last_d0 = d0;
         prev_wr = (wr0 === 1'b1);
      end else begin
         prev_wr = 1'b0;
         last_d0 = 8'h20;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic void build_line(input logic [23:0] f1, input logic [23:0] f2, input bit lzb,
                                      output logic [7:0] ln [15]);
      logic [23:0] f;
      logic [3:0]  n;
      bit          seen;
      for (int fi = 0; fi < 2; fi++) begin
         f    = (fi == 0) ? f1 : f2;
         seen = 1'b0;
         for (int k = 0; k < 6; k++) begin
            n = f[23-4*k -: 4];
            if (n > 4'd9) begin
               ln[fi*7+k] = 8'h3F;
               seen = 1'b1;
            end else if (n == 4'd0 && !seen && lzb && k < 5) begin
               ln[fi*7+k] = 8'h20;
            end else begin
               ln[fi*7+k] = 8'h30 + 8'(n);
               if (n != 4'd0) seen = 1'b1;
            end
         end
      end
      ln[6]  = 8'h20;
      ln[13] = 8'h0D;
      ln[14] = 8'h0A;
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic logic [23:0] rand_field();
      logic [23:0] f;
      int          r;
      f = 24'h0;
      for (int k = 0; k < 6; k++) begin
         r = $urandom_range(0, 15);
         if (r < 6)       f[4*k +: 4] = 4'h0;
         else if (r < 13) f[4*k +: 4] = 4'($urandom_range(1, 9));
         else             f[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      return f;
   endfunction

   task automatic wait_ready(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (rdy0 === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      tot++;
      if (!got) begin
         bad++;
         $display("FAIL %s wait_ready: ready stayed %b, want 1", name, rdy0);
      end
   endtask

   task automatic finish_line(input logic [7:0] e0 [15], input logic [7:0] e1 [15], input int t_first,
                              input int sp, input int ldb, input string name);
      bit got;
      bit sp_ok;
      got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock);
         if (ld_count > ldb) begin
            got = 1'b1;
            break;
         end
      end
      tot++;
      if (!got) begin
         bad++;
         $display("FAIL %s line_timeout: got %0d bytes and no line_done, want 15 then line_done", name, q0.size());
      end
      @(negedge clock);
      tot++;
      if (rdy0 !== 1'b1) begin bad++; $display("FAIL %s ready_after: got %b want 1", name, rdy0); end
      tot++;
      if (ld0_o !== 1'b0) begin bad++; $display("FAIL %s line_done_width: got %b want 0", name, ld0_o); end
      tot++;
      if (ld_count != ldb + 1) begin bad++; $display("FAIL %s line_done_count: got %0d want %0d", name, ld_count - ldb, 1); end
      tot++;
      if (q0.size() != 15 || q1.size() != 15) begin
         bad++;
         $display("FAIL %s byte_count: got %0d/%0d want 15", name, q0.size(), q1.size());
      end else begin
         for (int i = 0; i < 15; i++) begin
            tot++;
            if (q0[i] !== e0[i]) begin bad++; $display("FAIL %s plain_byte%0d: got %h want %h", name, i, q0[i], e0[i]); end
            tot++;
            if (q1[i] !== e1[i]) begin bad++; $display("FAIL %s blank_byte%0d: got %h want %h", name, i, q1[i], e1[i]); end
         end
      end
      if (t_first >= 0 && qt.size() > 0) begin
         tot++;
         if (qt[0] != t_first) begin bad++; $display("FAIL %s first_wr_cycle: got %0d want %0d", name, qt[0], t_first); end
      end
      if (sp > 0 && qt.size() > 1) begin
         sp_ok = 1'b1;
         for (int i = 1; i < qt.size(); i++) if (qt[i] - qt[i-1] != sp) sp_ok = 1'b0;
         tot++;
         if (!sp_ok) begin bad++; $display("FAIL %s byte_spacing: got uneven gaps, want %0d cycles", name, sp); end
      end
      tot++;
      if (dr0 !== 8'(exp_drop) || dr1 !== 8'(exp_drop)) begin
         bad++;
         $display("FAIL %s dropped: got %0d/%0d want %0d", name, dr0, dr1, exp_drop);
      end
   endtask

   task automatic run_line(input logic [23:0] f1, input logic [23:0] f2, input int sp, input string name);
      logic [7:0] e0 [15];
      logic [7:0] e1 [15];
      int t_acc;
      int ldb;
      build_line(f1, f2, 1'b0, e0);
      build_line(f1, f2, 1'b1, e1);
      wait_ready(name);
      @(negedge clock);
      field1_bcd = f1;
      field2_bcd = f2;
      start = 1'b1;
      q0.delete(); q1.delete(); qt.delete();
      ldb = ld_count;
      @(posedge clock);
      #1;
      t_acc = cyc;
      start = 1'b0;
      field1_bcd = 24'($urandom);
      field2_bcd = 24'($urandom);
      finish_line(e0, e1, t_acc, sp, ldb, name);
   endtask

   task automatic test_reset();
      reset_active_low = 1'b0;
      repeat (3) @(negedge clock);
      tot++; if (wr0 !== 1'b0 || wr1 !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b/%b want 0", wr0, wr1); end
      tot++; if (d0 !== 8'h20 || d1 !== 8'h20) begin bad++; $display("FAIL reset_data: got %h/%h want 20", d0, d1); end
      tot++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b/%b want 1", rdy0, rdy1); end
      tot++; if (ld0_o !== 1'b0 || ld1_o !== 1'b0) begin bad++; $display("FAIL reset_line_done: got %b/%b want 0", ld0_o, ld1_o); end
      tot++; if (dr0 !== 8'h00 || dr1 !== 8'h00) begin bad++; $display("FAIL reset_dropped: got %h/%h want 00", dr0, dr1); end
      reset_active_low = 1'b1;
      repeat (2) @(negedge clock);
      tot++; if (rdy0 !== 1'b1 || wr0 !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got ready=%b wr=%b want 1/0", rdy0, wr0); end
   endtask

   task automatic test_spec_vectors();
      mode = M_NORMAL;
      run_line(24'h000123, 24'h045678, 12, "spec_digits");
      run_line(24'h000000, 24'hFFFFFF, 12, "spec_zero_invalid");
      run_line(24'h00A001, 24'h100000, 12, "spec_invalid_run");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            mode = M_NORMAL; uart_busy = 1'b0; busy_cnt = 0;
            run_line(rand_field(), rand_field(), 12, "random_normal");
         end else begin
            mode = M_NEVER; uart_busy = 1'b0; busy_cnt = 0;
            run_line(rand_field(), rand_field(), 6, "random_timeout");
         end
      end
      mode = M_NORMAL;
   endtask

   task automatic test_timeout();
      mode = M_NEVER; uart_busy = 1'b0; busy_cnt = 0;
      run_line(24'h123456, 24'h000000, 6, "busy_never_rises");
      mode = M_NORMAL;
   endtask

   task automatic test_held_start();
      logic [7:0] e0 [15];
      logic [7:0] e1 [15];
      int n;
      int ldb;
      build_line(24'h987654, 24'h000009, 1'b0, e0);
      build_line(24'h987654, 24'h000009, 1'b1, e1);
      wait_ready("held_start");
      @(negedge clock);
      field1_bcd = 24'h987654;
      field2_bcd = 24'h000009;
      start = 1'b1;
      q0.delete(); q1.delete(); qt.delete();
      ldb = ld_count;
      n = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock);
         n++;
         if (ld_count > ldb) break;
      end
      #1;
      start = 1'b0;
      exp_drop = sat(exp_drop + n - 1);
      finish_line(e0, e1, -1, 12, ldb, "held_start");
      repeat (20) @(negedge clock);
      tot++;
      if (q0.size() != 15) begin bad++; $display("FAIL held_start_one_line: got %0d bytes want 15", q0.size()); end
   endtask

   task automatic test_done_start();
      logic [7:0] e0 [15];
      logic [7:0] e1 [15];
      int t_acc;
      int ldb;
      bit got;
      build_line(24'h000050, 24'h700000, 1'b0, e0);
      build_line(24'h000050, 24'h700000, 1'b1, e1);
      wait_ready("done_start");
      @(negedge clock);
      field1_bcd = rand_field();
      field2_bcd = rand_field();
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         #1;
         if (ld0_o === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      tot++;
      if (!got) begin bad++; $display("FAIL done_start_reach_done: got no line_done, want one"); end
      field1_bcd = 24'h000050;
      field2_bcd = 24'h700000;
      start = 1'b1;
      q0.delete(); q1.delete(); qt.delete();
      ldb = ld_count;
      @(posedge clock);
      exp_drop = sat(exp_drop + 1);
      #1;
      tot++;
      if (rdy0 !== 1'b1) begin bad++; $display("FAIL done_start_ready: got %b want 1", rdy0); end
      @(posedge clock);
      #1;
      t_acc = cyc;
      start = 1'b0;
      field1_bcd = 24'($urandom);
      field2_bcd = 24'($urandom);
      finish_line(e0, e1, t_acc, 12, ldb, "done_start");
   endtask

   task automatic test_saturation_stuck();
      logic [7:0] e0 [15];
      logic [7:0] e1 [15];
      int t_rel;
      int ldb;
      build_line(24'h000007, 24'h0B0000, 1'b0, e0);
      build_line(24'h000007, 24'h0B0000, 1'b1, e1);
      wait_ready("stuck");
      mode = M_MANUAL;
      uart_busy = 1'b1;
      @(negedge clock);
      field1_bcd = 24'h000007;
      field2_bcd = 24'h0B0000;
      start = 1'b1;
      q0.delete(); q1.delete(); qt.delete();
      ldb = ld_count;
      repeat (301) @(posedge clock);
      #1;
      start = 1'b0;
      exp_drop = sat(exp_drop + 300);
      @(negedge clock);
      tot++;
      if (q0.size() != 0 || wr0 !== 1'b0) begin bad++; $display("FAIL stuck_no_wr: got %0d strobes want 0", q0.size()); end
      tot++;
      if (dr0 !== 8'hFF || dr1 !== 8'hFF) begin bad++; $display("FAIL dropped_saturate: got %h/%h want ff", dr0, dr1); end
      @(posedge clock);
      #2;
      uart_busy = 1'b0;
      busy_cnt = 0;
      mode = M_NORMAL;
      t_rel = cyc;
      finish_line(e0, e1, t_rel, 12, ldb, "stuck_release");
   endtask

   task automatic test_reset_midline();
      bit got;
      mode = M_NORMAL;
      wait_ready("midline");
      @(negedge clock);
      field1_bcd = rand_field();
      field2_bcd = rand_field();
      start = 1'b1;
      q0.delete(); q1.delete(); qt.delete();
      @(posedge clock);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock);
         if (q0.size() >= 8) begin
            got = 1'b1;
            break;
         end
      end
      tot++;
      if (!got) begin bad++; $display("FAIL midline_reach_idx7: got %0d bytes want 8", q0.size()); end
      #3;
      reset_active_low = 1'b0;
      mode = M_MANUAL;
      uart_busy = 1'b0;
      busy_cnt = 0;
      exp_drop = 0;
      #1;
      tot++; if (wr0 !== 1'b0 || wr1 !== 1'b0) begin bad++; $display("FAIL midline_wr: got %b/%b want 0", wr0, wr1); end
      tot++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL midline_ready: got %b/%b want 1", rdy0, rdy1); end
      tot++; if (d0 !== 8'h20 || dr0 !== 8'h00) begin bad++; $display("FAIL midline_data_drop: got %h/%h want 20/00", d0, dr0); end
      repeat (3) @(negedge clock);
      reset_active_low = 1'b1;
      mode = M_NORMAL;
      repeat (4) @(negedge clock);
      tot++;
      if (q0.size() != 8) begin bad++; $display("FAIL midline_abandon: got %0d bytes want 8", q0.size()); end
      run_line(rand_field(), rand_field(), 12, "after_reset");
   endtask

   initial begin
      test_reset();
      test_spec_vectors();
      test_random();
      test_timeout();
      test_held_start();
      test_done_start();
      test_saturation_stuck();
      test_reset_midline();
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/uart_bcd_line_sender.md
UART_BCD_LINE_SENDER -- requirements
Module: uart_bcd_line_sender

Interface
REQ-001 Parameter LEADING_ZERO_BLANKING, default 0; when 1, leading zero digits of each field are sent as space (8'h20), and the least-significant digit of each field is never blanked.
REQ-002 Parameter SEPARATOR, default 8'h20; the byte sent between the two fields.
REQ-003 Parameter BUSY_RISE_TIMEOUT, default 4; the maximum number of cycles to wait for uart_busy to rise after a strobe.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_active_low  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to send one line; sampled each rising edge.
REQ-007 field1_bcd  input  24  six BCD digits, [23:20] most significant.
REQ-008 field2_bcd  input  24  six BCD digits, [23:20] most significant.
REQ-009 uart_busy  input  1  busy flag from the uart transmitter.
REQ-010 uart_wr  output  1  one-cycle write strobe to the uart.
REQ-011 uart_data  output  8  byte to transmit; valid whenever uart_wr is 1.
REQ-012 ready  output  1  registered; 1 when idle and able to accept start.
REQ-013 line_done  output  1  one-cycle pulse after the final byte of a line completes.
REQ-014 dropped_starts  output  8  saturating count of start requests that were refused.

Function
REQ-015 Start is accepted at an edge where start==1 and ready==1: field1_bcd and field2_bcd are latched, and ready goes to 0 on that same edge.
REQ-016 An accepted line is 15 bytes in index order:
- 0-5: field1 digits, MSD first
- 6: SEPARATOR
- 7-12: field2 digits, MSD first
- 13: 8'h0D
- 14: 8'h0A
REQ-017 Digit encoding:
- nybble 0-9 -> {4'h3, nybble}
- nybble A-F -> 8'h3F ('?')
- blanking is applied only to valid zero digits that precede the first nonzero digit of the field.
REQ-018 Invalid (A-F) nybbles are never blanked; an invalid nybble ends the leading-zero run.
REQ-019 The state machine has states IDLE, STROBE, WAIT_HI, WAIT_LO and DONE.
REQ-020 IDLE -> STROBE on accepted start.
REQ-021 STROBE -> WAIT_HI, transition rules:
- in STROBE, if uart_busy==0, uart_wr=1 for exactly one cycle with uart_data = byte[index], then go to WAIT_HI;
- if uart_busy==1, stay in STROBE with uart_wr=0.
REQ-022 WAIT_HI -> WAIT_LO when uart_busy==1, or after BUSY_RISE_TIMEOUT cycles in WAIT_HI, whichever comes first.
REQ-023 WAIT_LO ends when uart_busy==0 is sampled:
- if index<14: increment index and go to STROBE;
- if index==14: go to DONE.
REQ-024 DONE lasts one cycle, with line_done=1 and ready set to 1 on exit; next state is IDLE.
REQ-025 uart_data is held stable from its strobe until the next strobe.
REQ-026 uart_wr is never asserted outside STROBE.
REQ-027 uart_wr is never asserted on two consecutive cycles.
REQ-028 Latency: the first uart_wr occurs one cycle after the accepting edge, provided uart_busy==0.
REQ-029 Byte spacing: next uart_wr occurs one cycle after uart_busy is sampled 0 in WAIT_LO.
REQ-030 start==1 at an edge where ready==0 is not accepted, and dropped_starts increments by 1.
REQ-031 dropped_starts saturates at 8'hFF; it does not wrap.
REQ-032 A start asserted continuously while ready==0 counts once per cycle.
REQ-033 Input field changes after acceptance do not affect the line being sent.
REQ-034 A start arriving in the DONE cycle is refused and counted; a start on the following edge (ready==1) is accepted.
REQ-035 The index counter is 4 bits and never exceeds 14.

Reset
REQ-036 While reset_active_low==0, independent of clock, the block holds:
- state IDLE, index 0
- uart_wr=0, uart_data=8'h20
- ready=1, line_done=0
- dropped_starts=0
- latched fields = 0
REQ-037 Reset asserted mid-line abandons the line immediately; no further strobe occurs.
REQ-038 Reset deassertion takes effect on the next rising edge; start is first acceptable at that edge.

Verification
REQ-039 Scenario: field1=24'h000123, field2=24'h045678, blanking 0, uart model raising busy 1 cycle after wr for 10 cycles -> bytes "000123 045678\r\n" (15 strobes), then one line_done pulse, then ready=1.
REQ-040 Scenario: same fields with LEADING_ZERO_BLANKING=1 -> "   123  45678\r\n"; field1=24'h000000 -> "     0" for that field.
REQ-041 Scenario: field1=24'h00A001, blanking 1 -> "  ?001"; field2=24'hFFFFFF -> "??????".
REQ-042 Scenario: start held high for a full line (~165 cycles busy) -> exactly one line sent; dropped_starts equals the count of refused cycles; after forcing 300 refused starts -> 8'hFF.
REQ-043 Scenario: uart_busy never rises -> each byte proceeds after 4 WAIT_HI cycles; uart_busy stuck 1 before start -> no uart_wr until it falls.
REQ-044 Scenario: reset pulsed during byte index 7 -> uart_wr=0 and ready=1 immediately; next start sends a complete fresh 15-byte line from index 0.
